// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, control encodings, FSM states, IF/ID payload.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned STALL_W     = 6;

  localparam logic RST_ENABLE_N = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic BRANCH       = 1'b1;

  localparam logic [INST_W-1:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F0   = 3'd1,
    ST_F1   = 3'd2,
    ST_F2   = 3'd3,
    ST_F3   = 3'd4,
    ST_HOLD = 3'd5
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } ifid_payload_t;

  // Byte lane fetched in each request state (little-endian assembly).
  function automatic logic [1:0] byte_sel(input fetch_state_e s);
    case (s)
      ST_F1:   return 2'd1;
      ST_F2:   return 2'd2;
      ST_F3:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide read handshake between the fetch stage and the memory controller.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                   mem_req_o;
  logic [INST_ADDR_W-1:0] mem_addr_o;
  logic                   mem_ack_i;
  logic [BYTE_W-1:0]      mem_rdata_i;

  modport master (output mem_req_o, mem_addr_o, input mem_ack_i, mem_rdata_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_ack_i, mem_rdata_i);
endinterface

// File: rtl/if_fetch_if_id.sv
// IF/ID pipeline register: hold under stall, flush on redirect, load on handoff, bubble otherwise.
module if_fetch_if_id
  import if_fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          flush,
  input  logic          load,
  input  ifid_payload_t din,
  output ifid_payload_t dout,
  output logic          valid
);

  // Register update; pc is kept when a bubble or flush is inserted.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      dout.pc   <= ZERO_WORD;
      dout.inst <= NOP_INST;
      valid     <= 1'b0;
    end else if (!hold) begin
      if (flush) begin
        dout.inst <= NOP_INST;
        valid     <= 1'b0;
      end else if (load) begin
        dout  <= din;
        valid <= 1'b1;
      end else begin
        dout.inst <= NOP_INST;
        valid     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit words from four byte reads and feeds the IF/ID register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0]      NOP_INST = NOP_INST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall_i,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_address_i,
  if_fetch_if.master             mem,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0]      inst_o,
  output logic                   inst_valid_o,
  output logic                   if_stall_o
);

  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [INST_W-1:0]      buf_q, buf_d;
  logic                   req_q, req_d;
  logic [INST_ADDR_W-1:0] addr_q, addr_d;
  logic                   if_stall_q;
  logic                   branch_take;
  logic                   handoff;
  logic [4:0]             lane_lsb;
  ifid_payload_t          ifid_in, ifid_q;

  // Upper stall bits and the redirect byte offset are not used by this stage.
  logic unused_inputs;
  assign unused_inputs = ^{stall_i[STALL_W-1:2], branch_address_i[1:0]};

  // Next-state, fetch PC, byte buffer and next request/address.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    buf_d       = buf_q;
    handoff     = 1'b0;
    lane_lsb    = {byte_sel(state_q), 3'b000};
    branch_take = (branch_flag_i == BRANCH) && (stall_i[1] == NO_STOP);

    if (branch_take) begin
      // Redirect wins over everything, including a same-cycle ack or handoff.
      state_d    = ST_F0;
      fetch_pc_d = {branch_address_i[INST_ADDR_W-1:2], 2'b00};
      buf_d      = ZERO_WORD;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (stall_i[0] == NO_STOP) state_d = ST_F0;
        end
        ST_F0, ST_F1, ST_F2, ST_F3: begin
          if (mem.mem_ack_i) begin
            buf_d[lane_lsb +: BYTE_W] = mem.mem_rdata_i;
            state_d = (state_q == ST_F3) ? ST_HOLD : fetch_state_e'(state_q + 3'd1);
          end
        end
        ST_HOLD: begin
          if (stall_i[1] == NO_STOP) begin
            handoff    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = (stall_i[0] == STOP) ? ST_IDLE : ST_F0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    req_d  = (state_d == ST_F0) || (state_d == ST_F1) ||
             (state_d == ST_F2) || (state_d == ST_F3);
    addr_d = req_d ? (fetch_pc_d + INST_ADDR_W'(byte_sel(state_d))) : ZERO_WORD;
  end

  // State, fetch PC, buffer and registered bus/stall outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      buf_q      <= ZERO_WORD;
      req_q      <= 1'b0;
      addr_q     <= ZERO_WORD;
      if_stall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      buf_q      <= buf_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      if_stall_q <= req_d;
    end
  end

  assign ifid_in.pc   = fetch_pc_q;
  assign ifid_in.inst = buf_q;

  if_fetch_if_id #(.NOP_INST(NOP_INST)) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall_i[1]),
    .flush (branch_take),
    .load  (handoff),
    .din   (ifid_in),
    .dout  (ifid_q),
    .valid (inst_valid_o)
  );

  assign mem.mem_req_o  = req_q;
  assign mem.mem_addr_o = addr_q;
  assign pc_o           = ifid_q.pc;
  assign inst_o         = ifid_q.inst;
  assign if_stall_o     = if_stall_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a byte-memory responder and an IF/ID scoreboard.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = 6'b0;
  logic        br_flag = 1'b0;
  logic [31:0] br_addr = 32'h0;
  logic [31:0] pc_o, inst_o;
  logic        inst_valid_o, if_stall_o;

  if_fetch_if mem_bus ();

  if_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .branch_flag_i    (br_flag),
    .branch_address_i (br_addr),
    .mem              (mem_bus),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .inst_valid_o     (inst_valid_o),
    .if_stall_o       (if_stall_o)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [1024];
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] hold_addr = 32'hFFFF_FFFF;
  int          hold_cnt = 0;
  bit          force_ack = 1'b0;
  bit          saw_valid = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int i;
    i = int'(a[9:0]);
    return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: decides ack/data for the coming edge from the current request.
  task automatic drive_mem();
    if (force_ack) begin
      mem_bus.mem_ack_i   = 1'b1;
      mem_bus.mem_rdata_i = 8'hEE;
    end else if (mem_bus.mem_req_o === 1'b1) begin
      if (mem_bus.mem_addr_o == hold_addr && hold_cnt > 0) begin
        mem_bus.mem_ack_i = 1'b0;
        hold_cnt--;
      end else begin
        mem_bus.mem_ack_i   = 1'b1;
        mem_bus.mem_rdata_i = mem[mem_bus.mem_addr_o[9:0]];
      end
    end else begin
      mem_bus.mem_ack_i = 1'b0;
    end
  endtask

  // One clock; IF/ID output is compared against the scoreboard when valid.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    saw_valid = (inst_valid_o === 1'b1);
    if (saw_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_unexpected: observed pc %h inst %h expected no valid", pc_o, inst_o);
      end else begin
        e = sb.pop_front();
        check("sb_pc", pc_o, e.pc);
        check("sb_inst", inst_o, e.inst);
      end
    end
    drive_mem();
  endtask

  task automatic wait_addr(input string tag, input logic [31:0] a);
    int n = 0;
    while (!(mem_bus.mem_req_o === 1'b1 && mem_bus.mem_addr_o === a) && n < 40) begin
      step();
      n++;
    end
    check({tag, "_addr"}, mem_bus.mem_addr_o, a);
    check({tag, "_req"}, 32'(mem_bus.mem_req_o), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    saw_valid = 1'b0;
    while (!saw_valid && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(saw_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    mem_bus.mem_ack_i   = 1'b0;
    mem_bus.mem_rdata_i = 8'h00;

    // Reset values
    #12;
    check("rst_req", 32'(mem_bus.mem_req_o), 32'd0);
    check("rst_addr", mem_bus.mem_addr_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_inst", inst_o, NOP);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_stall", 32'(if_stall_o), 32'd0);

    // Basic fetch from RESET_PC, ack every cycle
    @(negedge clk);
    rst = 1'b1;
    drive_mem();
    e.pc = 32'h0; e.inst = 32'h0010_0513; sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_req", 32'(mem_bus.mem_req_o), 32'd1);
      check("t1_addr", mem_bus.mem_addr_o, 32'(k));
      check("t1_ifstall", 32'(if_stall_o), 32'd1);
    end
    step();
    check("t1_hold_req", 32'(mem_bus.mem_req_o), 32'd0);
    check("t1_hold_ifstall", 32'(if_stall_o), 32'd0);
    step();
    check("t1_valid_cycle6", 32'(saw_valid), 32'd1);
    check("t1_next_addr", mem_bus.mem_addr_o, 32'h4);
    check("t1_next_req", 32'(mem_bus.mem_req_o), 32'd1);

    // Byte 2 acked three cycles late
    hold_addr = 32'h6;
    hold_cnt  = 3;
    e.pc = 32'h4; e.inst = word_at(32'h4); sb.push_back(e);
    wait_addr("t2_wait", 32'h6);
    for (int j = 0; j < 3; j++) begin
      check("t2_addr", mem_bus.mem_addr_o, 32'h6);
      check("t2_req", 32'(mem_bus.mem_req_o), 32'd1);
      check("t2_ifstall", 32'(if_stall_o), 32'd1);
      step();
    end
    check("t2_addr_ack", mem_bus.mem_addr_o, 32'h6);
    wait_valid("t2_valid");

    // Stall held in HOLD
    e.pc = 32'h8; e.inst = word_at(32'h8); sb.push_back(e);
    wait_addr("t3_wait", 32'hB);
    stall = 6'b000011;
    step();
    for (int j = 0; j < 4; j++) begin
      check("t3_req", 32'(mem_bus.mem_req_o), 32'd0);
      check("t3_ifstall", 32'(if_stall_o), 32'd0);
      check("t3_valid", 32'(inst_valid_o), 32'd0);
      check("t3_pc", pc_o, 32'h4);
      check("t3_inst", inst_o, NOP);
      step();
    end
    stall = 6'b000000;
    step();
    check("t3_release_valid", 32'(saw_valid), 32'd1);
    check("t3_resume_req", 32'(mem_bus.mem_req_o), 32'd1);
    check("t3_resume_addr", mem_bus.mem_addr_o, 32'hC);

    // Redirect during F2 with an ack in the same cycle
    wait_addr("t4_wait", 32'hE);
    br_flag = 1'b1;
    br_addr = 32'h0000_0103;
    step();
    br_flag = 1'b0;
    check("t4_addr", mem_bus.mem_addr_o, 32'h100);
    check("t4_req", 32'(mem_bus.mem_req_o), 32'd1);
    check("t4_valid", 32'(inst_valid_o), 32'd0);
    check("t4_inst", inst_o, NOP);

    // Redirect coinciding with handoff
    wait_addr("t5_wait", 32'h103);
    step();
    check("t5_hold_req", 32'(mem_bus.mem_req_o), 32'd0);
    br_flag = 1'b1;
    br_addr = 32'h0000_0200;
    step();
    br_flag = 1'b0;
    check("t5_valid", 32'(inst_valid_o), 32'd0);
    check("t5_inst", inst_o, NOP);
    check("t5_addr", mem_bus.mem_addr_o, 32'h200);
    e.pc = 32'h200; e.inst = word_at(32'h200); sb.push_back(e);
    wait_valid("t5_target_valid");
    check("t5_next_addr", mem_bus.mem_addr_o, 32'h204);

    // Misaligned redirect near the top of memory, then PC wrap
    br_flag = 1'b1;
    br_addr = 32'hFFFF_FFFE;
    step();
    br_flag = 1'b0;
    check("t6_addr", mem_bus.mem_addr_o, 32'hFFFF_FFFC);
    e.pc = 32'hFFFF_FFFC; e.inst = word_at(32'hFFFF_FFFC); sb.push_back(e);
    wait_valid("t6_valid");
    check("t6_wrap_addr", mem_bus.mem_addr_o, 32'h0);
    check("t6_wrap_req", 32'(mem_bus.mem_req_o), 32'd1);

    // Asynchronous reset during F1, stray ack afterwards
    wait_addr("t7_wait", 32'h1);
    rst = 1'b0;
    force_ack = 1'b1;
    mem_bus.mem_ack_i = 1'b1;
    stall = 6'b000001;
    #1;
    check("t7_req", 32'(mem_bus.mem_req_o), 32'd0);
    check("t7_addr", mem_bus.mem_addr_o, 32'h0);
    check("t7_ifstall", 32'(if_stall_o), 32'd0);
    check("t7_valid", 32'(inst_valid_o), 32'd0);
    check("t7_inst", inst_o, NOP);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_mem();
    step();
    step();
    check("t7_idle_req", 32'(mem_bus.mem_req_o), 32'd0);
    check("t7_idle_ifstall", 32'(if_stall_o), 32'd0);
    force_ack = 1'b0;
    stall = 6'b000000;
    drive_mem();
    e.pc = 32'h0; e.inst = 32'h0010_0513; sb.push_back(e);
    wait_addr("t7_restart", 32'h0);
    wait_valid("t7_valid_after");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
